// File: rtl/sv12_lrm_p0639_muxn_rr.sv
// sv12_lrm_p0639_muxn_rr: N-to-1 valid/ready funnel with a single registered
// output stage. Arbitration is round-robin (ARB_MODE=0) or fixed priority,
// lowest index wins (ARB_MODE=1).
//
// Optional build macro: MUXN_PARITY_EN adds out_par, the even parity (XOR
// reduction) of the registered out_data.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   per-channel request                         [N_CH]
//   in_data    packed channel data, ch i at [i*WIDTH +: WIDTH]
//   in_ready   per-channel accept, combinational           [N_CH]
//   out_valid  output register holds a beat
//   out_data   registered selected data                    [WIDTH]
//   out_sel    index of the channel that produced out_data [SEL_W]
//   out_par    parity of out_data (MUXN_PARITY_EN only)
//   out_ready  downstream accept
module sv12_lrm_p0639_muxn_rr #(
   parameter int unsigned N_CH     = 4,
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned ARB_MODE = 0,
   localparam int unsigned SEL_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_CH-1:0]         in_valid,
   input  logic [N_CH*WIDTH-1:0]   in_data,
   output logic [N_CH-1:0]         in_ready,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_sel,
`ifdef MUXN_PARITY_EN
   output logic                    out_par,
`endif
   input  logic                    out_ready
);

   logic [WIDTH-1:0] ch_data [N_CH];

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [SEL_W-1:0] out_sel_q,   out_sel_d;
   logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

   logic             found_c;
   logic [SEL_W-1:0] grant_c;
   logic             load_en_c;
   logic             xfer_c;
   int               idx_c;

   // Unpack the flat data bus into one word per channel.
   for (genvar i = 0; i < int'(N_CH); i++) begin : g_unpack
      assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
   end

   // Grant search: rotate the start point to rr_ptr in round-robin mode, start
   // at 0 in fixed-priority mode; the first valid channel encountered wins.
   always_comb begin
      found_c = 1'b0;
      grant_c = '0;
      idx_c   = 0;
      for (int k = 0; k < int'(N_CH); k++) begin
         idx_c = (ARB_MODE == 0) ? int'(rr_ptr_q) + k : k;
         if (idx_c >= int'(N_CH)) idx_c = idx_c - int'(N_CH);
         if (!found_c && in_valid[SEL_W'(idx_c)]) begin
            found_c = 1'b1;
            grant_c = SEL_W'(idx_c);
         end
      end
   end

   // Handshake and next-state: load when empty or draining this cycle.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      rr_ptr_d    = rr_ptr_q;
      in_ready    = '0;

      load_en_c = !out_valid_q || out_ready;
      xfer_c    = load_en_c && found_c;
      in_ready[grant_c] = xfer_c;

      if (xfer_c) begin
         out_valid_d = 1'b1;
         out_data_d  = ch_data[grant_c];
         out_sel_d   = grant_c;
         // Pointer moves past the winner; wraps at the last channel.
         if (ARB_MODE == 0) begin
            rr_ptr_d = (grant_c == SEL_W'(N_CH - 1)) ? '0 : grant_c + SEL_W'(1);
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Output stage and arbitration pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

`ifdef MUXN_PARITY_EN
   logic out_par_q;

   // Parity tracks the data register on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out_par_q <= 1'b0;
      else        out_par_q <= ^out_data_d;
   end

   assign out_par = out_par_q;
`endif

endmodule

// File: tb/tb_sv12_lrm_p0639_muxn_rr.sv
// Testbench: round-robin and fixed-priority instances driven by shared
// stimulus, checked against a cycle-level behavioural model.
module tb_sv12_lrm_p0639_muxn_rr;

   logic        clk;
   logic        rst_n;
   logic [3:0]  in_valid;
   logic [31:0] in_data;
   logic        out_ready;

   logic [3:0]  in_ready_rr,  in_ready_fp;
   logic        out_valid_rr, out_valid_fp;
   logic [7:0]  out_data_rr,  out_data_fp;
   logic [1:0]  out_sel_rr,   out_sel_fp;
`ifdef MUXN_PARITY_EN
   logic        out_par_rr,   out_par_fp;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Model state per mode (0 = round-robin, 1 = fixed priority).
   logic       m_valid [2];
   logic [7:0] m_data  [2];
   int         m_sel   [2];
   int         m_ptr   [2];

   sv12_lrm_p0639_muxn_rr #(.N_CH(4), .WIDTH(8), .ARB_MODE(0)) u_rr (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready_rr),
      .out_valid (out_valid_rr),
      .out_data  (out_data_rr),
      .out_sel   (out_sel_rr),
`ifdef MUXN_PARITY_EN
      .out_par   (out_par_rr),
`endif
      .out_ready (out_ready)
   );

   sv12_lrm_p0639_muxn_rr #(.N_CH(4), .WIDTH(8), .ARB_MODE(1)) u_fp (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready_fp),
      .out_valid (out_valid_fp),
      .out_data  (out_data_fp),
      .out_sel   (out_sel_fp),
`ifdef MUXN_PARITY_EN
      .out_par   (out_par_fp),
`endif
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int exp_grant(input int mode, input int ptr, input logic [3:0] v);
      logic [3:0] t;
      for (int k = 0; k < 4; k++) begin
         int i;
         i = (mode == 0) ? (ptr + k) % 4 : k;
         t = v >> i;
         if (t[0]) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_valid[m] = 1'b0;
         m_data[m]  = 8'h00;
         m_sel[m]   = 0;
         m_ptr[m]   = 0;
      end
   endtask

   // Compare every DUT output of both instances against the model.
   task automatic check_model();
      for (int m = 0; m < 2; m++) begin
         int         g;
         logic [3:0] er;
         string      p;
         p  = (m == 0) ? "rr" : "fp";
         g  = exp_grant(m, m_ptr[m], in_valid);
         er = ((!m_valid[m] || out_ready) && g >= 0) ? 4'(1 << g) : 4'd0;
         check_eq({p, "_in_ready"},  32'((m == 0) ? in_ready_rr  : in_ready_fp),  32'(er));
         check_eq({p, "_out_valid"}, 32'((m == 0) ? out_valid_rr : out_valid_fp), 32'(m_valid[m]));
         check_eq({p, "_out_data"},  32'((m == 0) ? out_data_rr  : out_data_fp),  32'(m_data[m]));
         check_eq({p, "_out_sel"},   32'((m == 0) ? out_sel_rr   : out_sel_fp),   32'(m_sel[m]));
`ifdef MUXN_PARITY_EN
         check_eq({p, "_out_par"},   32'((m == 0) ? out_par_rr   : out_par_fp),   32'(^m_data[m]));
`endif
      end
   endtask

   task automatic model_step();
      for (int m = 0; m < 2; m++) begin
         int g;
         g = exp_grant(m, m_ptr[m], in_valid);
         if ((!m_valid[m] || out_ready) && g >= 0) begin
            m_valid[m] = 1'b1;
            m_data[m]  = 8'(in_data >> (g * 8));
            m_sel[m]   = g;
            if (m == 0) m_ptr[m] = (g + 1) % 4;
         end else if (out_ready) begin
            m_valid[m] = 1'b0;
         end
      end
   endtask

   // One clock: apply inputs, check pre-edge, advance model, land at edge+1.
   task automatic cycle(input logic [3:0] v, input logic [31:0] d, input logic ordy);
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      #1;
      check_model();
      model_step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 4'h0;
      in_data   = 32'h0;
      out_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_model();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Asynchronous reset with a beat held in the output register.
      cycle(4'b0001, 32'h0000_003C, 1'b0);
      check_eq("pre_reset_valid", 32'(out_valid_rr), 32'd1);
      check_eq("pre_reset_data",  32'(out_data_rr),  32'h3C);
      #2;
      in_valid = 4'b0000;
      rst_n    = 1'b0;
      #1;
      model_reset();
      check_eq("async_rst_valid", 32'(out_valid_rr), 32'd0);
      check_eq("async_rst_data",  32'(out_data_rr),  32'd0);
      check_eq("async_rst_sel",   32'(out_sel_rr),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq("post_rst_in_ready", 32'(in_ready_rr), 32'd0);
      cycle(4'b0000, 32'h0, 1'b1);
      cycle(4'b0000, 32'h0, 1'b1);

      // Round-robin over four always-valid channels.
      for (int k = 0; k < 8; k++) begin
         cycle(4'b1111, 32'hA3A2_A1A0, 1'b1);
         check_eq("rr_seq_sel",  32'(out_sel_rr),  32'(k % 4));
         check_eq("rr_seq_data", 32'(out_data_rr), 32'(8'hA0 + 8'(k % 4)));
      end

      // Skip and wrap: ptr to 3, then sparse requests.
      cycle(4'b0100, 32'hB3B2_B1B0, 1'b1);
      check_eq("wrap_g2", 32'(out_sel_rr), 32'd2);
      cycle(4'b0010, 32'hB3B2_B1B0, 1'b1);
      check_eq("wrap_g1", 32'(out_sel_rr), 32'd1);
      cycle(4'b1001, 32'hB3B2_B1B0, 1'b1);
      check_eq("wrap_g3", 32'(out_sel_rr), 32'd3);
      cycle(4'b1111, 32'hB3B2_B1B0, 1'b1);
      check_eq("wrap_g0", 32'(out_sel_rr), 32'd0);

      // Backpressure: stall three cycles, then drain and accept ch2.
      cycle(4'b0001, 32'h0000_0011, 1'b1);
      for (int k = 0; k < 3; k++) begin
         cycle(4'b0100, 32'h005C_0000, 1'b0);
         check_eq("stall_valid",    32'(out_valid_rr), 32'd1);
         check_eq("stall_data",     32'(out_data_rr),  32'h11);
         check_eq("stall_in_ready", 32'(in_ready_rr),  32'd0);
      end
      cycle(4'b0100, 32'h005C_0000, 1'b1);
      check_eq("bp_release_data", 32'(out_data_rr), 32'h5C);
      check_eq("bp_release_sel",  32'(out_sel_rr),  32'd2);

      // Fixed priority: ch2 starves ch3 until it drops.
      for (int k = 0; k < 4; k++) begin
         cycle(4'b1100, 32'hD3D2_0000, 1'b1);
         check_eq("fp_hold_sel",  32'(out_sel_fp),  32'd2);
         check_eq("fp_hold_data", 32'(out_data_fp), 32'hD2);
      end
      cycle(4'b1000, 32'hD3D2_0000, 1'b1);
      check_eq("fp_ch3_sel", 32'(out_sel_fp), 32'd3);

`ifdef MUXN_PARITY_EN
      cycle(4'b0001, 32'h0000_0007, 1'b1);
      check_eq("par_07", 32'(out_par_rr), 32'd1);
      cycle(4'b0001, 32'h0000_0003, 1'b1);
      check_eq("par_03", 32'(out_par_rr), 32'd0);
`endif

      // Random traffic against the model.
      for (int k = 0; k < 400; k++) begin
         cycle(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) != 0));
      end
      cycle(4'b0000, 32'h0, 1'b1);
      cycle(4'b0000, 32'h0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
